reorder_buffer: RTL and testbench

//  Two-wide circular reorder buffer between dispatch and retire in the OoO RISC-V core.

---
 rtl/reorder_buffer_if.sv | 50 +++++
 rtl/reorder_buffer.sv | 109 ++++++++++
 tb/tb_reorder_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retire bundle of the two-wide reorder buffer.
// The master side is the core (dispatch, FUs, retire consumer); the ROB is the slave.
interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
);
    logic              alloc_valid_1, alloc_valid_2;
    logic [4:0]        alloc_rd_1, alloc_rd_2;
    logic [PREG_W-1:0] alloc_pd_1, alloc_pd_2;
    logic [PREG_W-1:0] alloc_opd_1, alloc_opd_2;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;

    logic              cmpl_valid_1, cmpl_valid_2;
    logic [IDX_W-1:0]  cmpl_idx_1, cmpl_idx_2;
    logic [DATA_W-1:0] cmpl_data_1, cmpl_data_2;

    logic              ret_valid_1, ret_valid_2;
    logic [4:0]        ret_rd_1, ret_rd_2;
    logic [PREG_W-1:0] ret_pd_1, ret_pd_2;
    logic [DATA_W-1:0] ret_data_1, ret_data_2;
    logic              ret_free_1, ret_free_2;
    logic [PREG_W-1:0] ret_opd_1, ret_opd_2;

    logic [IDX_W:0]    count;
    logic              empty, full;

    modport master (
        output alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
               alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2,
               cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
               cmpl_data_1, cmpl_data_2,
        input  alloc_ready, alloc_idx_1, alloc_idx_2,
               ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2, ret_pd_1, ret_pd_2,
               ret_data_1, ret_data_2, ret_free_1, ret_free_2, ret_opd_1, ret_opd_2,
               count, empty, full
    );

    modport slave (
        input  alloc_valid_1, alloc_valid_2, alloc_rd_1, alloc_rd_2,
               alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2,
               cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
               cmpl_data_1, cmpl_data_2,
        output alloc_ready, alloc_idx_1, alloc_idx_2,
               ret_valid_1, ret_valid_2, ret_rd_1, ret_rd_2, ret_pd_1, ret_pd_2,
               ret_data_1, ret_data_2, ret_free_1, ret_free_2, ret_opd_1, ret_opd_2,
               count, empty, full
    );
endinterface

// File: rtl/reorder_buffer.sv
// Two-wide circular reorder buffer: in-order allocate at tail, out-of-order complete,
// in-order retire of up to two entries per cycle from head.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    reorder_buffer_if.slave rob
);
    typedef struct packed {
        logic [4:0]        rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] opd;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);
    localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid, done, valid_nx, done_nx;
    entry_t           ent [DEPTH];
    logic [IDX_W-1:0] head, tail, head_1, tail_1;
    logic [IDX_W:0]   cnt;
    logic             do_a1, do_a2, do_r1, do_r2, do_c1, do_c2;
    logic [1:0]       n_alloc, n_ret;

    assign head_1 = head + 1'b1;
    assign tail_1 = tail + 1'b1;

    // Readiness uses the pre-edge count only, so same-cycle retires never enable an alloc.
    assign rob.alloc_ready = (cnt <= READY_MAX);
    assign rob.alloc_idx_1 = tail;
    assign rob.alloc_idx_2 = tail_1;

    assign do_a1 = rob.alloc_ready & rob.alloc_valid_1;
    assign do_a2 = do_a1 & rob.alloc_valid_2;
    assign do_r1 = valid[head] & done[head];
    assign do_r2 = do_r1 & valid[head_1] & done[head_1];
    assign do_c1 = rob.cmpl_valid_1 & valid[rob.cmpl_idx_1] & ~done[rob.cmpl_idx_1];
    assign do_c2 = rob.cmpl_valid_2 & valid[rob.cmpl_idx_2] & ~done[rob.cmpl_idx_2];

    assign n_alloc = 2'(do_a1) + 2'(do_a2);
    assign n_ret   = 2'(do_r1) + 2'(do_r2);

    assign rob.count = cnt;
    assign rob.empty = (cnt == '0);
    assign rob.full  = (cnt == FULL_CNT);

    assign rob.ret_valid_1 = do_r1;
    assign rob.ret_valid_2 = do_r2;
    assign rob.ret_rd_1    = do_r1 ? ent[head].rd     : '0;
    assign rob.ret_rd_2    = do_r2 ? ent[head_1].rd   : '0;
    assign rob.ret_pd_1    = do_r1 ? ent[head].pd     : '0;
    assign rob.ret_pd_2    = do_r2 ? ent[head_1].pd   : '0;
    assign rob.ret_opd_1   = do_r1 ? ent[head].opd    : '0;
    assign rob.ret_opd_2   = do_r2 ? ent[head_1].opd  : '0;
    assign rob.ret_data_1  = do_r1 ? ent[head].data   : '0;
    assign rob.ret_data_2  = do_r2 ? ent[head_1].data : '0;
    assign rob.ret_free_1  = do_r1 & (ent[head].rd != 5'd0);
    assign rob.ret_free_2  = do_r2 & (ent[head_1].rd != 5'd0);

    // Retiring, allocated and completing entries are disjoint, so update order is irrelevant.
    always_comb begin
        valid_nx = valid;
        done_nx  = done;
        if (do_r1) begin valid_nx[head]   = 1'b0; done_nx[head]   = 1'b0; end
        if (do_r2) begin valid_nx[head_1] = 1'b0; done_nx[head_1] = 1'b0; end
        if (do_a1) begin valid_nx[tail]   = 1'b1; done_nx[tail]   = 1'b0; end
        if (do_a2) begin valid_nx[tail_1] = 1'b1; done_nx[tail_1] = 1'b0; end
        if (do_c1) done_nx[rob.cmpl_idx_1] = 1'b1;
        if (do_c2) done_nx[rob.cmpl_idx_2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head  <= head + IDX_W'(n_ret);
            tail  <= tail + IDX_W'(n_alloc);
            cnt   <= cnt + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
            valid <= valid_nx;
            done  <= done_nx;
        end
    end

    // Payload needs no reset: it is only observable through ret_valid-gated outputs.
    always_ff @(posedge clk) begin
        if (do_a1) begin
            ent[tail].rd  <= rob.alloc_rd_1;
            ent[tail].pd  <= rob.alloc_pd_1;
            ent[tail].opd <= rob.alloc_opd_1;
        end
        if (do_a2) begin
            ent[tail_1].rd  <= rob.alloc_rd_2;
            ent[tail_1].pd  <= rob.alloc_pd_2;
            ent[tail_1].opd <= rob.alloc_opd_2;
        end
        // Port 1 is written last so it wins when both ports target the same tag.
        if (do_c2) ent[rob.cmpl_idx_2].data <= rob.cmpl_data_2;
        if (do_c1) ent[rob.cmpl_idx_1].data <= rob.cmpl_data_1;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table vectors plus hand sequences, with a program-order
// scoreboard queue that predicts every retirement.
module tb_reorder_buffer;
    localparam int DEPTH = 16, IDX_W = 4, PREG_W = 6, DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if #(.IDX_W(IDX_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) rif ();

    reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .rob(rif)
    );

    typedef struct {
        logic a1, a2;
        logic [4:0] rd1, rd2;
        logic [5:0] pd1, pd2;
        logic c1, c2;
        logic [3:0] ci1, ci2;
        logic [31:0] cd1, cd2;
        int ecount;          // -1: no table expectation
        logic [1:0] erv;     // {ret_valid_2, ret_valid_1}
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [4:0] rd;
        logic [5:0] pd, opd;
    } sb_t;

    sb_t q[$];
    logic m_valid[DEPTH];
    logic m_done[DEPTH];
    logic [31:0] m_data[DEPTH];
    logic [3:0] m_tail;
    int errors = 0, checks = 0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int a1, a2, rd1, pd1, rd2, pd2,
                                 input int c1, ci1, input logic [31:0] cd1,
                                 input int c2, ci2, input logic [31:0] cd2,
                                 input int ec, erv);
        vec_t v;
        v.a1 = a1[0]; v.a2 = a2[0];
        v.rd1 = 5'(rd1); v.pd1 = 6'(pd1); v.rd2 = 5'(rd2); v.pd2 = 6'(pd2);
        v.c1 = c1[0]; v.ci1 = 4'(ci1); v.cd1 = cd1;
        v.c2 = c2[0]; v.ci2 = 4'(ci2); v.cd2 = cd2;
        v.ecount = ec; v.erv = 2'(erv);
        return v;
    endfunction

    task automatic reset_model();
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_done[i] = 1'b0; m_data[i] = '0; end
        m_tail = '0;
    endtask

    task automatic drive(input vec_t v);
        rif.alloc_valid_1 = v.a1; rif.alloc_valid_2 = v.a2;
        rif.alloc_rd_1 = v.rd1; rif.alloc_pd_1 = v.pd1; rif.alloc_opd_1 = 6'(v.rd1);
        rif.alloc_rd_2 = v.rd2; rif.alloc_pd_2 = v.pd2; rif.alloc_opd_2 = 6'(v.rd2);
        rif.cmpl_valid_1 = v.c1; rif.cmpl_idx_1 = v.ci1; rif.cmpl_data_1 = v.cd1;
        rif.cmpl_valid_2 = v.c2; rif.cmpl_idx_2 = v.ci2; rif.cmpl_data_2 = v.cd2;
    endtask

    // Drive one cycle, check at negedge against the scoreboard, then update the model.
    task automatic step(input vec_t v);
        logic ready, rv1, rv2;
        sb_t e;
        drive(v);
        @(negedge clk);
        ready = (q.size() <= DEPTH - 2);
        rv1 = (q.size() > 0) && m_done[q[0].idx];
        rv2 = rv1 && (q.size() > 1) && m_done[q[1].idx];
        chk("count", 64'(rif.count), 64'(q.size()));
        chk("alloc_ready", 64'(rif.alloc_ready), 64'(ready));
        chk("empty_full", {rif.empty, rif.full}, {q.size() == 0, q.size() == DEPTH});
        chk("ret_valid", {rif.ret_valid_2, rif.ret_valid_1}, {rv2, rv1});
        if (v.ecount >= 0) begin
            chk("tbl_count", 64'(rif.count), 64'(v.ecount));
            chk("tbl_ret_valid", {rif.ret_valid_2, rif.ret_valid_1}, v.erv);
        end
        if (v.a1 && ready) chk("alloc_idx_1", rif.alloc_idx_1, m_tail);
        if (v.a1 && v.a2 && ready) chk("alloc_idx_2", rif.alloc_idx_2, m_tail + 4'd1);
        if (rv1) begin
            e = q[0];
            chk("ret_port1", {rif.ret_rd_1, rif.ret_pd_1, rif.ret_opd_1, rif.ret_data_1, rif.ret_free_1},
                {e.rd, e.pd, e.opd, m_data[e.idx], e.rd != 5'd0});
        end else
            chk("idle_port1", {rif.ret_rd_1, rif.ret_pd_1, rif.ret_opd_1, rif.ret_data_1, rif.ret_free_1}, 0);
        if (rv2) begin
            e = q[1];
            chk("ret_port2", {rif.ret_rd_2, rif.ret_pd_2, rif.ret_opd_2, rif.ret_data_2, rif.ret_free_2},
                {e.rd, e.pd, e.opd, m_data[e.idx], e.rd != 5'd0});
        end else
            chk("idle_port2", {rif.ret_rd_2, rif.ret_pd_2, rif.ret_opd_2, rif.ret_data_2, rif.ret_free_2}, 0);
        // Completes: only busy entries; port 1 wins a shared tag.
        if (v.c2 && m_valid[v.ci2] && !m_done[v.ci2] && !(v.c1 && v.ci1 == v.ci2)) begin
            m_done[v.ci2] = 1'b1; m_data[v.ci2] = v.cd2;
        end
        if (v.c1 && m_valid[v.ci1] && !m_done[v.ci1]) begin
            m_done[v.ci1] = 1'b1; m_data[v.ci1] = v.cd1;
        end
        if (rv1) begin e = q.pop_front(); m_valid[e.idx] = 1'b0; m_done[e.idx] = 1'b0; end
        if (rv2) begin e = q.pop_front(); m_valid[e.idx] = 1'b0; m_done[e.idx] = 1'b0; end
        if (v.a1 && ready) begin
            q.push_back('{m_tail, v.rd1, v.pd1, 6'(v.rd1)});
            m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0; m_tail++;
            if (v.a2) begin
                q.push_back('{m_tail, v.rd2, v.pd2, 6'(v.rd2)});
                m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0; m_tail++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(mkv(0,0,0,0,0,0, 0,0,0, 0,0,0, -1,0));
    endtask

    // Complete the two oldest pending entries per cycle until the ROB drains.
    task automatic drain();
        for (int n = 0; n < 64 && q.size() > 0; n++) begin
            logic h1, h2;
            logic [3:0] t1, t2;
            h1 = 1'b0; h2 = 1'b0; t1 = '0; t2 = '0;
            foreach (q[j]) begin
                if (!m_done[q[j].idx]) begin
                    if (!h1) begin h1 = 1'b1; t1 = q[j].idx; end
                    else if (!h2) begin h2 = 1'b1; t2 = q[j].idx; end
                end
            end
            step(mkv(0,0,0,0,0,0, int'(h1), int'(t1), $urandom, int'(h2), int'(t2), $urandom, -1,0));
        end
        chk("drain_count", 64'(rif.count), 0);
        chk("drain_empty", 64'(rif.empty), 1);
    endtask

    initial begin
        reset_model();
        drive(mkv(0,0,0,0,0,0, 0,0,0, 0,0,0, -1,0));
        #12;
        chk("reset_count", 64'(rif.count), 0);
        chk("reset_flags", {rif.empty, rif.full, rif.alloc_ready}, 3'b101);
        chk("reset_ret", {rif.ret_valid_2, rif.ret_valid_1, rif.ret_free_2, rif.ret_free_1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // In-order retire, rd=0 / duplicate completion, slot 2 without slot 1.
        tbl[0]  = mkv(1,1,5,33,6,34, 0,0,0,           0,0,0,           0,0);
        tbl[1]  = mkv(0,0,0,0,0,0,   1,1,32'hAAAA0001, 0,0,0,           2,0);
        tbl[2]  = mkv(0,0,0,0,0,0,   1,0,32'hBBBB0000, 0,0,0,           2,0);
        tbl[3]  = mkv(0,0,0,0,0,0,   0,0,0,           0,0,0,           2,3);
        tbl[4]  = mkv(0,0,0,0,0,0,   0,0,0,           0,0,0,           0,0);
        tbl[5]  = mkv(1,1,0,40,7,41, 0,0,0,           0,0,0,           0,0);
        tbl[6]  = mkv(0,0,0,0,0,0,   1,2,32'h00001111, 1,2,32'h00002222, 2,0);
        tbl[7]  = mkv(0,0,0,0,0,0,   0,0,0,           1,3,32'h00003333, 2,1);
        tbl[8]  = mkv(0,0,0,0,0,0,   0,0,0,           0,0,0,           1,1);
        tbl[9]  = mkv(0,0,0,0,0,0,   0,0,0,           0,0,0,           0,0);
        tbl[10] = mkv(0,1,9,42,9,42, 0,0,0,           0,0,0,           0,0);
        tbl[11] = mkv(0,0,0,0,0,0,   0,0,0,           0,0,0,           0,0);
        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Fill to 16, then show that 15 still blocks allocation.
        for (int i = 0; i < 8; i++) step(mkv(1,1, 10+i, 20+i, 11+i, 21+i, 0,0,0, 0,0,0, 2*i, 0));
        step(mkv(1,1,3,3,4,4, 0,0,0, 0,0,0, 16,0));
        step(mkv(1,1,3,3,4,4, 1, int'(q[0].idx), 32'hF00D0001, 0,0,0, 16,0));
        step(mkv(1,1,3,3,4,4, 0,0,0, 0,0,0, 16,1));
        step(mkv(1,1,3,3,4,4, 0,0,0, 0,0,0, 15,0));
        step(mkv(0,0,0,0,0,0, 0,0,0, 0,0,0, 15,0));
        chk("at15_not_ready", 64'(rif.alloc_ready), 0);
        drain();

        // Hold at 14 with two retiring and two allocating in the same cycle.
        for (int i = 0; i < 6; i++) step(mkv(1,1, 1+i, 40+i, 2+i, 50+i, 0,0,0, 0,0,0, -1,0));
        step(mkv(1,1,12,12,13,13, 1, int'(q[0].idx), 32'h5A5A0000, 1, int'(q[1].idx), 32'h5A5A0001, 12,0));
        step(mkv(1,1,14,14,15,15, 0,0,0, 0,0,0, 14,3));
        step(mkv(0,0,0,0,0,0, 0,0,0, 0,0,0, 14,0));
        drain();

        // 20 alloc/complete/retire pairs: tags wrap through 15 -> 0.
        for (int i = 0; i < 20; i++) begin
            int pt;
            pt = int'(m_tail) - 2;
            step(mkv(1,1, 1+(i%30), i+1, 2+(i%29), i+2,
                     int'(i > 0), pt & 15, $urandom, int'(i > 0), (pt+1) & 15, $urandom, -1,0));
        end
        drain();

        // Asynchronous reset mid-traffic with a retirement pending.
        step(mkv(1,1,8,8,9,9, 0,0,0, 0,0,0, -1,0));
        step(mkv(1,1,8,8,9,9, 1, int'(q[0].idx), 32'hC0DE0000, 0,0,0, -1,0));
        drive(mkv(0,0,0,0,0,0, 0,0,0, 0,0,0, -1,0));
        chk("pre_reset_ret", 64'(rif.ret_valid_1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(rif.count), 0);
        chk("midrst_flags", {rif.empty, rif.full, rif.alloc_ready}, 3'b101);
        chk("midrst_ret", {rif.ret_valid_2, rif.ret_valid_1, rif.ret_free_2, rif.ret_free_1}, 0);
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        step(mkv(1,1,5,6,7,8, 0,0,0, 0,0,0, 0,0));
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
